// File: rtl/sqrt_iter.sv
// rtl/sqrt_iter.sv - iterative bit-pair integer square root, one root bit per clock
// Optional remainder output enabled by defining SQRT_REM_EN.
module sqrt_iter #(
  parameter  int W  = 8,
  localparam int RW = W / 2
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          start,
  input  logic [W-1:0]  A,
  output logic          busy,
  output logic          ack,
`ifdef SQRT_REM_EN
  output logic [RW:0]   rem,
`endif
  output logic [RW-1:0] sol
);

  if (W < 4 || (W % 2) != 0) begin : g_bad_width
    $error("sqrt_iter: W must be even and >= 4");
  end

  localparam int CW = (RW > 1) ? $clog2(RW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  opnd;
  logic [RW-1:0] q;
  logic [RW+1:0] r;
  logic [CW-1:0] cnt;

  logic [RW+1:0] r_sh;
  logic [RW+1:0] t;
  logic [RW+1:0] r_sub;
  logic          ge;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shifted remainder brings in the next operand bit pair; trial divisor is 4q+1.
  always_comb begin
    r_sh  = (r << 2) | {{RW{1'b0}}, opnd[W-1:W-2]};
    t     = {q, 2'b01};
    ge    = (r_sh >= t);
    r_sub = r_sh - t;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      opnd <= '0;
      q    <= '0;
      r    <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opnd <= A;
            q    <= '0;
            r    <= '0;
            cnt  <= CW'(RW - 1);
          end
        end
        CALC: begin
          opnd <= opnd << 2;
          r    <= ge ? r_sub : r_sh;
          q    <= (q << 1) | {{(RW-1){1'b0}}, ge};
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Results and ack are registered on the edge leaving DONE; sol holds until the next result.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ack <= 1'b0;
      sol <= '0;
`ifdef SQRT_REM_EN
      rem <= '0;
`endif
    end else begin
      ack <= (state == DONE);
      if (state == DONE) begin
        sol <= q;
`ifdef SQRT_REM_EN
        rem <= r[RW:0];
`endif
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/sqrt_iter.md
Name: sqrt_iter

Overview:
- Parametrised iterative integer square root with a start/ack handshake.
- Computes floor(sqrt(A)) for an unsigned W-bit operand using the bit-pair (digit-by-digit) method.
- Produces one root bit per clock, so latency is W/2 cycles regardless of operand value.
- Serves as the successor to the fixed 8-bit linear-search root block. Used by datapath blocks that need magnitude/distance roots of any even width.

Parameters:
- W, 8, operand width in bits; must be even and >= 4 (elaboration error otherwise).
- RW, W/2, root width in bits; derived, not overridable.

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- A  in  W  unsigned operand; sampled on the accepting edge only
- busy  out  1  high while a request is in flight (CALC or DONE)
- ack  out  1  one-cycle pulse: sol (and rem) valid
- sol  out  RW  floor(sqrt(A)); held until the next accepted start
- rem  out  RW+1  A - sol*sol; present only with SQRT_REM_EN

Behaviour:
- Reset is asynchronous and active-low; clock is the single Clk.
- Rst_n low: state=IDLE; busy=0, ack=0, sol=0, rem=0; internal operand, partial root, partial remainder and counter all cleared.
- Reset mid-operation aborts the computation. No ack is issued for the aborted request.
- States:
  - IDLE: start=1 at a rising edge -> latch A into shift register, clear partial root and remainder, load counter=RW-1, go to CALC. start=0 -> stay.
  - CALC, one iteration per cycle:
    - r' = (r<<2) | top two bits of the operand register; operand shifts left by 2.
    - t = (q<<2) | 1.
    - If r' >= t: r = r' - t, q = (q<<1)|1. Otherwise r = r', q = q<<1.
    - Counter decrements. After the iteration with counter=0 -> DONE.
  - DONE: sol <= q, rem <= r, ack=1 for exactly this cycle, then unconditionally -> IDLE.
- Widths: partial remainder is RW+2 bits; the compare/subtract uses RW+2 bits; the final remainder always fits in RW+1 bits (max 2*sol).
- Latency: if start is sampled at edge k, ack is high in the cycle following edge k+RW+1. sol/rem update at the same edge that raises ack.
- busy rises at the accepting edge and falls at the edge that leaves DONE. busy=0 in the cycle after ack.
- start while busy (CALC or DONE) is ignored: not queued, operand not re-latched.
- start held high continuously: a new request is accepted at each return to IDLE, giving back-to-back throughput of one result every RW+2 cycles.
- A changes after the accepting edge: no effect on the in-flight result.
- sol/rem are not cleared at request start. They retain the previous result until the new DONE.
- Boundary values:
  - A=0 -> sol=0, rem=0.
  - A=2^W-1 -> sol=2^RW-1, rem=2^(RW+1)-2.
  - Exact squares -> rem=0.

Optional Feature:
- Macro: SQRT_REM_EN.
- Defined: rem port exists and is registered in DONE as above.
- Undefined: rem port and its output register are absent. The internal partial remainder is still kept (needed for the algorithm). sol, ack, busy and latency are identical in both builds.

Test Plan:
- W=8, A=81, start pulsed one cycle -> busy=1 next cycle; ack pulse exactly 5 edges after the accepting edge; sol=9, rem=0.
- W=8, sweep A=0..255 with back-to-back start held high -> for each: sol=floor(sqrt(A)), rem=A-sol^2; spot values A=80 -> 8/16, A=0 -> 0/0, A=255 -> 15/30; one result every 6 cycles.
- W=16, A=65535 -> sol=255, rem=510, ack 9 edges after accept; A=10000 -> sol=100, rem=0.
- W=8, accept A=200; in CALC drive start=1 with A=4 -> ignored; result sol=14, rem=4; no second ack until a fresh start in IDLE.
- W=8, accept A=144; assert Rst_n=0 for 3 cycles during CALC -> busy, ack, sol, rem go to 0 immediately (asynchronously); no ack afterwards; next request A=49 -> sol=7, rem=0.
- Build without SQRT_REM_EN, W=8, A=99 -> sol=9, ack timing unchanged; elaboration shows no rem port.
